led_flow_sched: RTL and testbench



---
 rtl/led_flow_sched.sv | 125 ++++++++++++
 tb/tb_led_flow_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_flow_sched.sv
// led_flow_sched: running-light LED sequencer. It steps the pattern at a prescaled rate,
// picks the pattern style from mode, and freezes while the pause level is high.
`default_nettype none

module led_flow_sched #(
    parameter int LED_NUM  = 8,
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic               clk_out,
    input  logic               rst,
    input  logic               pause,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               step,
    output logic               paused
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   TERM = CNT_W'(TICK_DIV - 1);
    localparam logic [LED_NUM-1:0] ONE  = LED_NUM'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pre_q, pre_d;
    logic [LED_NUM-1:0] led_q, led_d, led_nxt;
    logic               dir_q, dir_d, dir_nxt;   // 0 = moving left, 1 = moving right
    logic               step_q, step_d;
    logic               paused_q;
    logic               adv, tick;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (pause)  state_d = S_PAUSE;
            S_PAUSE: if (!pause) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Pause is honoured in the very cycle it is sampled, even at terminal count.
    assign adv  = (state_q == S_RUN) && !pause;
    assign tick = adv && (pre_q == TERM);

    always_comb begin
        pre_d = pre_q;
        if (adv) begin
            pre_d = tick ? '0 : pre_q + CNT_W'(1);
        end
    end

    always_comb begin
        led_nxt = led_q;
        dir_nxt = dir_q;
        case (mode)
            2'd0: led_nxt = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
            2'd1: led_nxt = {led_q[0], led_q[LED_NUM-1:1]};
            2'd2: begin
                if (!dir_q) begin
                    if (led_q[LED_NUM-1]) begin
                        dir_nxt = 1'b1;
                        led_nxt = led_q >> 1;
                    end else begin
                        led_nxt = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        dir_nxt = 1'b0;
                        led_nxt = led_q << 1;
                    end else begin
                        led_nxt = led_q >> 1;
                    end
                end
            end
            default: led_nxt = (&led_q) ? '0 : {led_q[LED_NUM-2:0], 1'b1};
        endcase
        // Fill mode empties the bank on purpose; every other mode must never go dark.
        if ((mode != 2'd3) && (led_q == '0)) begin
            led_nxt = ONE;
            dir_nxt = dir_q;
        end
    end

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = tick;
        if (state_q == S_IDLE) begin
            led_d = ONE;
        end else if (tick) begin
            led_d = led_nxt;
            dir_d = dir_nxt;
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            led_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            paused_q <= (state_d == S_PAUSE);
        end
    end

    assign led    = led_q;
    assign step   = step_q;
    assign paused = paused_q;

endmodule

`default_nettype wire

// File: tb/tb_led_flow_sched.sv
// Directed self-checking bench for led_flow_sched with LED_NUM=4, TICK_DIV=4.
`default_nettype none

module tb_led_flow_sched;

    logic       clk_out = 1'b0;
    logic       rst     = 1'b1;
    logic       pause   = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic [3:0] led;
    logic       step;
    logic       paused;

    int checks = 0;
    int errors = 0;

    led_flow_sched #(
        .LED_NUM (4),
        .TICK_DIV(4),
        .CNT_W   (2)
    ) dut (
        .clk_out(clk_out),
        .rst    (rst),
        .pause  (pause),
        .mode   (mode),
        .led    (led),
        .step   (step),
        .paused (paused)
    );

    always #5 clk_out = ~clk_out;

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    // Runs one full step interval; reports how many of the first three cycles
    // showed a step or an led change, plus led/step after the fourth edge.
    task automatic run_interval(output int bad_hold, output logic [3:0] led_at, output logic step_at);
        logic [3:0] start;
        start    = led;
        bad_hold = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (step !== 1'b0 || led !== start) bad_hold++;
        end
        tick();
        led_at  = led;
        step_at = step;
    endtask

    task automatic test_reset();
        rst = 1'b1; pause = 1'b0; mode = 2'd0;
        tick(); tick();
        checks++;
        if (led !== 4'b0000 || step !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: led=%b step=%b paused=%b, expected led=0000 step=0 paused=0", led, step, paused);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (led !== 4'b0001 || step !== 1'b0) begin
            errors++;
            $display("FAIL idle_load: led=%b step=%b, expected led=0001 step=0", led, step);
        end
    endtask

    task automatic test_rotate_left();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int bad; logic [3:0] l; logic s;
        mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            run_interval(bad, l, s);
            checks++;
            if (bad != 0 || l !== exp_seq[i] || s !== 1'b1) begin
                errors++;
                $display("FAIL rotl_step%0d: led=%b step=%b early=%0d, expected led=%b step=1 early=0", i, l, s, bad, exp_seq[i]);
            end
        end
    endtask

    task automatic test_pingpong();
        logic [3:0] exp_seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        int bad; logic [3:0] l; logic s;
        mode = 2'd2;
        for (int i = 0; i < 6; i++) begin
            run_interval(bad, l, s);
            checks++;
            if (bad != 0 || l !== exp_seq[i] || s !== 1'b1) begin
                errors++;
                $display("FAIL pingpong_step%0d: led=%b step=%b early=%0d, expected led=%b step=1 early=0", i, l, s, bad, exp_seq[i]);
            end
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_seq [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
        int bad; logic [3:0] l; logic s;
        mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            run_interval(bad, l, s);
            checks++;
            if (bad != 0 || l !== exp_seq[i] || s !== 1'b1) begin
                errors++;
                $display("FAIL fill_step%0d: led=%b step=%b early=%0d, expected led=%b step=1 early=0", i, l, s, bad, exp_seq[i]);
            end
        end
    endtask

    // Entered just after a step with led=0001, so the prescaler is at 0.
    task automatic test_pause_hold();
        int bad;
        mode = 2'd0;
        tick(); tick();
        pause = 1'b1;
        tick();
        checks++;
        if (paused !== 1'b1 || step !== 1'b0 || led !== 4'b0001) begin
            errors++;
            $display("FAIL pause_entry: paused=%b step=%b led=%b, expected paused=1 step=0 led=0001", paused, step, led);
        end
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (paused !== 1'b1 || step !== 1'b0 || led !== 4'b0001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_frozen: bad_cycles=%0d, expected 0", bad);
        end
        pause = 1'b0;
        tick();
        checks++;
        if (paused !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL pause_exit: paused=%b step=%b, expected paused=0 step=0", paused, step);
        end
        tick();
        checks++;
        if (step !== 1'b0 || led !== 4'b0001) begin
            errors++;
            $display("FAIL resume_partial1: step=%b led=%b, expected step=0 led=0001", step, led);
        end
        tick();
        checks++;
        if (step !== 1'b1 || led !== 4'b0010) begin
            errors++;
            $display("FAIL resume_partial2: step=%b led=%b, expected step=1 led=0010", step, led);
        end
    endtask

    // Entered just after a step with led=0010; three edges bring the prescaler to terminal count.
    task automatic test_pause_terminal();
        int bad;
        tick(); tick(); tick();
        pause = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (step !== 1'b0 || led !== 4'b0010) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tc_pause_wins: bad_cycles=%0d, expected 0", bad);
        end
        pause = 1'b0;
        tick();
        checks++;
        if (step !== 1'b0 || led !== 4'b0010) begin
            errors++;
            $display("FAIL tc_resume_edge: step=%b led=%b, expected step=0 led=0010", step, led);
        end
        tick();
        checks++;
        if (step !== 1'b1 || led !== 4'b0100) begin
            errors++;
            $display("FAIL tc_first_run: step=%b led=%b, expected step=1 led=0100", step, led);
        end
    endtask

    task automatic test_async_reset();
        int bad; logic [3:0] l; logic s;
        mode  = 2'd1;
        pause = 1'b1;
        tick(); tick();
        checks++;
        if (paused !== 1'b1 || led !== 4'b0100) begin
            errors++;
            $display("FAIL prereset_state: paused=%b led=%b, expected paused=1 led=0100", paused, led);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (led !== 4'b0000 || step !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: led=%b step=%b paused=%b, expected 0000/0/0", led, step, paused);
        end
        pause = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (led !== 4'b0001 || step !== 1'b0) begin
            errors++;
            $display("FAIL restart_load: led=%b step=%b, expected led=0001 step=0", led, step);
        end
        run_interval(bad, l, s);
        checks++;
        if (bad != 0 || l !== 4'b1000 || s !== 1'b1) begin
            errors++;
            $display("FAIL rotr_step: led=%b step=%b early=%0d, expected led=1000 step=1 early=0", l, s, bad);
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_pingpong();
        test_fill();
        test_pause_hold();
        test_pause_terminal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
